// File: rtl/i2s_encoder.sv
`default_nettype none
// ============================================================================
// Module      : i2s_encoder
// Description : Philips I2S transmitter and bus master.
//               Generates ck/lr from clock and serialises one 16-bit
//               left/right sample pair per frame.
//               Optional macro I2S_SLOT32_EN widens each slot to 32 bits
//               (16 data bits followed by 16 zero bits).
// Revision    : 1.0 - initial release
// ============================================================================
module i2s_encoder #(
    parameter int DIV = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] lmidi,
    input  logic [15:0] rmidi,
    output logic        req,
    output logic        ck,
    output logic        lr,
    output logic        d
);

`ifdef I2S_SLOT32_EN
    localparam int c_slot_bits = 32;
`else
    localparam int c_slot_bits = 16;
`endif

    localparam logic [7:0] c_div_last = 8'(DIV - 1);
    localparam logic [5:0] c_slot     = 6'(c_slot_bits);
    localparam logic [5:0] c_bit_last = 6'(2 * c_slot_bits - 1);
    localparam logic [5:0] c_j_mask   = 6'(c_slot_bits - 1);

    logic [7:0]  r_dcnt;
    logic        r_ck;
    logic [5:0]  r_bcnt;
    logic        r_lr;
    logic        r_d;
    logic        r_req;
    logic [15:0] r_lh;
    logic [15:0] r_rh;

    logic [5:0]  w_b_next;
    logic        w_lr_next;
    logic [5:0]  w_j;
    logic [15:0] w_word;
    logic        w_bit;

    // The bit sent after a fall belongs to the index being left (k = b-1),
    // so the word is read from the holding registers before any new capture.
    always_comb begin
        w_b_next  = (r_bcnt == c_bit_last) ? 6'd0 : r_bcnt + 6'd1;
        w_lr_next = (w_b_next >= c_slot);
        w_j       = r_bcnt & c_j_mask;
        w_word    = (r_bcnt >= c_slot) ? r_rh : r_lh;
        w_bit     = 1'b0;
        if (w_j < 6'd16) begin
            w_bit = w_word[4'd15 - w_j[3:0]];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dcnt <= 8'd0;
            r_ck   <= 1'b0;
            r_bcnt <= c_bit_last;
            r_lr   <= 1'b1;
            r_d    <= 1'b0;
            r_req  <= 1'b0;
            r_lh   <= 16'd0;
            r_rh   <= 16'd0;
        end else begin
            r_req <= 1'b0;
            if (r_dcnt == c_div_last) begin
                r_dcnt <= 8'd0;
                r_ck   <= ~r_ck;
                if (r_ck) begin
                    r_bcnt <= w_b_next;
                    r_lr   <= w_lr_next;
                    r_d    <= w_bit;
                    if (w_b_next == 6'd0) begin
                        r_lh  <= lmidi;
                        r_rh  <= rmidi;
                        r_req <= 1'b1;
                    end
                end
            end else begin
                r_dcnt <= r_dcnt + 8'd1;
            end
        end
    end

    assign req = r_req;
    assign ck  = r_ck;
    assign lr  = r_lr;
    assign d   = r_d;

endmodule
`default_nettype wire

// File: tb/tb_i2s_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2s_encoder
// Description : Directed + randomised bench for i2s_encoder against a
//               frame/bit-stream reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2s_encoder;

    localparam int DIV = 4;
`ifdef I2S_SLOT32_EN
    localparam int S = 32;
`else
    localparam int S = 16;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] lmidi = 16'd0;
    logic [15:0] rmidi = 16'd0;
    logic        req;
    logic        ck;
    logic        lr;
    logic        d;

    int          vectors = 0;
    int          errors  = 0;
    int          t       = 0;
    bit          rand_in = 1'b0;
    logic [15:0] lq[$];
    logic [15:0] rq[$];

    i2s_encoder #(.DIV(DIV)) dut (
        .clock (clock),
        .reset (reset),
        .lmidi (lmidi),
        .rmidi (rmidi),
        .req   (req),
        .ck    (ck),
        .lr    (lr),
        .d     (d)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at t=%0d: observed %b expected %b", tag, t, obs, exp);
        end
    endtask

    // Model: t counts clocks since release; fall n happens at t = n*2*DIV.
    // The serial stream is the concatenation of captured frames delayed by
    // one bit period (bit n carries stream position n-2).
    task automatic step();
        logic rs;
        logic e_ck, e_lr, e_d, e_req;
        int n, m, f, pos, j;
        logic [15:0] w;
        rs = reset;
        @(posedge clock);
        #1;
        if (!rs) begin
            t = 0;
            lq.delete();
            rq.delete();
            e_ck = 1'b0; e_lr = 1'b1; e_d = 1'b0; e_req = 1'b0;
        end else begin
            t++;
            n     = t / (2 * DIV);
            e_ck  = ((t / DIV) % 2) == 1;
            e_req = (t >= 2 * DIV) && (((t - 2 * DIV) % (4 * S * DIV)) == 0);
            if (e_req) begin
                lq.push_back(lmidi);
                rq.push_back(rmidi);
            end
            e_lr = (n == 0) ? 1'b1 : (((n - 1) % (2 * S)) >= S);
            e_d  = 1'b0;
            if (n >= 2) begin
                m   = n - 2;
                f   = m / (2 * S);
                pos = m % (2 * S);
                j   = pos % S;
                w   = (pos < S) ? lq[f] : rq[f];
                if (j < 16) e_d = w[15 - j];
            end
        end
        check("ck", ck, e_ck);
        check("lr", lr, e_lr);
        check("d", d, e_d);
        check("req", req, e_req);
        if (rand_in) begin
            if ($urandom_range(7) == 0) lmidi = 16'($urandom);
            if ($urandom_range(7) == 0) rmidi = 16'($urandom);
        end
    endtask

    initial begin
        // Reset held, outputs at reset values
        reset = 1'b0;
        repeat (5) step();

        // Fixed pattern for two frames
        lmidi = 16'hA55A;
        rmidi = 16'h0FF1;
        reset = 1'b1;
        repeat (2 * 4 * S * DIV + 4 * DIV) step();

        // Capture window: change left sample one clock after a req
        while (!req && t < 100000) step();
        step();
        lmidi = 16'h1234;
        repeat (2 * 4 * S * DIV) step();

        // Random samples changing at arbitrary times
        rand_in = 1'b1;
        repeat (4 * 4 * S * DIV + 37) step();

        // Mid-frame reset for 10 clocks
        rand_in = 1'b0;
        reset = 1'b0;
        repeat (10) step();
        reset = 1'b1;
        rand_in = 1'b1;
        repeat (3 * 4 * S * DIV) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
